// File: rtl/motion_object_builder_pkg.sv
// Shared constants, attribute field codes and FSM encoding for the motion-object line builder.
package motion_object_builder_pkg;

    localparam int NUM_SPRITES = 8;
    localparam int CLEAR_LEN   = 256;

    typedef enum logic [1:0] {
        FIELD_NUM = 2'd0,
        FIELD_X   = 2'd1,
        FIELD_Y   = 2'd2,
        FIELD_EN  = 2'd3
    } attr_field_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETUP,
        ST_FETCH,
        ST_DRAIN
    } mob_state_e;

    typedef struct packed {
        logic [5:0] num;
        logic [9:0] x;
        logic [9:0] y;
        logic       en;
    } sprite_attr_t;

endpackage

// File: rtl/sprite_attr_table.sv
// Per-slot motion-object attributes: CPU write port, registered CPU read port and a
// combinational scan port used by the line builder.
module sprite_attr_table
    import motion_object_builder_pkg::*;
#(
    parameter int NUM_SPRITES = motion_object_builder_pkg::NUM_SPRITES
) (
    input  logic         i_Clk,
    input  logic         i_Reset_n,
    input  logic         i_Write,
    input  logic [4:0]   i_Addr,
    input  logic [11:0]  i_Data,
    output logic [11:0]  o_Rd_Data,
    input  logic [2:0]   i_Scan_Slot,
    output sprite_attr_t o_Scan_Attr
);

    sprite_attr_t table_q [NUM_SPRITES];
    logic [2:0]   addr_slot;
    attr_field_e  addr_field;
    logic [11:0]  rd_mux;
    logic         unused_bits;

    assign addr_slot   = i_Addr[4:2];
    assign addr_field  = attr_field_e'(i_Addr[1:0]);
    assign o_Scan_Attr = table_q[i_Scan_Slot];
    assign unused_bits = ^i_Data[11:10];

    always_comb begin
        // NOTE: default assigned first so no path through this block infers a latch.
        rd_mux = '0;
        if (int'(addr_slot) < NUM_SPRITES) begin
            case (addr_field)
                FIELD_NUM: rd_mux = {6'd0, table_q[addr_slot].num};
                FIELD_X:   rd_mux = {2'd0, table_q[addr_slot].x};
                FIELD_Y:   rd_mux = {2'd0, table_q[addr_slot].y};
                default:   rd_mux = {11'd0, table_q[addr_slot].en};
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            // NOTE: the table is explicitly reset because every slot must come up disabled.
            for (int s = 0; s < NUM_SPRITES; s++) table_q[s] <= '0;
            o_Rd_Data <= '0;
        end else begin
            if (i_Write && int'(addr_slot) < NUM_SPRITES) begin
                case (addr_field)
                    FIELD_NUM: table_q[addr_slot].num <= i_Data[5:0];
                    FIELD_X:   table_q[addr_slot].x   <= i_Data[9:0];
                    FIELD_Y:   table_q[addr_slot].y   <= i_Data[9:0];
                    default:   table_q[addr_slot].en  <= i_Data[0];
                endcase
            end
            o_Rd_Data <= rd_mux;
        end
    end

endmodule

// File: rtl/motion_object_builder.sv
// Builds one line of motion objects: clears the target line-RAM bank, then scans slots
// from highest to lowest, fetching 8 ROM pixels per visible sprite into the line RAM.
module motion_object_builder
    import motion_object_builder_pkg::*;
#(
    parameter int NUM_SPRITES = motion_object_builder_pkg::NUM_SPRITES,
    parameter int CLEAR_LEN   = motion_object_builder_pkg::CLEAR_LEN
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_Line_Start,
    input  logic [9:0]  i_Build_Row,
    input  logic        i_Attr_Write,
    input  logic [4:0]  i_Attr_Addr,
    input  logic [11:0] i_Attr_Data,
    output logic [11:0] o_Attr_Rd_Data,
    output logic [5:0]  o_Rom_Sprite_Num,
    output logic [2:0]  o_Rom_Row,
    output logic [2:0]  o_Rom_Col,
    input  logic [1:0]  i_Rom_Pixel,
    output logic        o_Lr_Write,
    output logic [10:0] o_Lr_Addr,
    output logic [1:0]  o_Lr_Data,
    output logic        o_Busy,
    output logic        o_Overflow
);

    localparam logic [7:0] LAST_CLR  = 8'(CLEAR_LEN - 1);
    localparam logic [2:0] LAST_SLOT = 3'(NUM_SPRITES - 1);

    mob_state_e   state;
    logic [7:0]   clr_cnt;
    logic [2:0]   slot;
    logic [2:0]   col;
    logic         bank;
    logic [9:0]   row;
    logic [5:0]   w_num;
    logic [7:0]   w_xh;
    logic [2:0]   w_line;
    logic         pix_pend;
    logic [8:0]   pix_xh;
    logic         busy;
    logic         ovf;
    sprite_attr_t scan;
    logic [9:0]   dy;
    logic         hit;
    logic         clearing;
    logic         pix_wr;
    logic         unused_bits;

    sprite_attr_table #(.NUM_SPRITES(NUM_SPRITES)) u_attr (
        .i_Clk       (i_Clk),
        .i_Reset_n   (i_Reset_n),
        .i_Write     (i_Attr_Write),
        .i_Addr      (i_Attr_Addr),
        .i_Data      (i_Attr_Data),
        .o_Rd_Data   (o_Attr_Rd_Data),
        .i_Scan_Slot (slot),
        .o_Scan_Attr (scan)
    );

    // A sprite is 16 lines tall and only the left half-screen (x < 512) is drawable.
    assign dy          = row - scan.y;
    assign hit         = scan.en && (dy[9:4] == 6'd0) && !scan.x[9];
    assign unused_bits = ^{scan.x[0], dy[0]};

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            slot     <= '0;
            col      <= '0;
            bank     <= 1'b0;
            row      <= '0;
            w_num    <= '0;
            w_xh     <= '0;
            w_line   <= '0;
            pix_pend <= 1'b0;
            pix_xh   <= '0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
        end else if (i_Line_Start) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            col      <= '0;
            bank     <= i_Build_Row[1];
            row      <= i_Build_Row;
            pix_pend <= 1'b0;
            busy     <= 1'b1;
            ovf      <= busy;
        end else begin
            ovf      <= 1'b0;
            // The ROM answers one cycle after each FETCH address, so its write lands a cycle later.
            pix_pend <= (state == ST_FETCH);
            pix_xh   <= {1'b0, w_xh} + {6'd0, col};
            case (state)
                ST_IDLE: ;
                ST_CLEAR: begin
                    if (clr_cnt == LAST_CLR) begin
                        state <= ST_SETUP;
                        slot  <= LAST_SLOT;
                    end else begin
                        clr_cnt <= clr_cnt + 8'd1;
                    end
                end
                ST_SETUP: begin
                    if (hit) begin
                        state  <= ST_FETCH;
                        col    <= '0;
                        w_num  <= scan.num;
                        w_xh   <= scan.x[8:1];
                        w_line <= dy[3:1];
                    end else if (slot == 3'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        slot <= slot - 3'd1;
                    end
                end
                ST_FETCH: begin
                    col <= col + 3'd1;
                    if (col == 3'd7) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (slot == 3'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_SETUP;
                        slot  <= slot - 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign clearing         = (state == ST_CLEAR);
    assign pix_wr           = pix_pend && (i_Rom_Pixel != 2'b00) && !pix_xh[8];
    assign o_Lr_Write       = clearing || pix_wr;
    assign o_Lr_Addr        = clearing ? {2'b00, bank, clr_cnt} :
                              pix_wr   ? {2'b00, bank, pix_xh[7:0]} : 11'd0;
    assign o_Lr_Data        = pix_wr ? i_Rom_Pixel : 2'b00;
    assign o_Rom_Sprite_Num = (state == ST_FETCH) ? w_num  : 6'd0;
    assign o_Rom_Row        = (state == ST_FETCH) ? w_line : 3'd0;
    assign o_Rom_Col        = (state == ST_FETCH) ? col    : 3'd0;
    assign o_Busy           = busy;
    assign o_Overflow       = ovf;

endmodule

// File: tb/tb_motion_object_builder.sv
// Directed bench for motion_object_builder: a line-level model predicts the ordered write
// stream, busy length and overflow, and a per-cycle compare process checks the DUT against it.
module tb_motion_object_builder;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Line_Start = 1'b0;
    logic [9:0]  i_Build_Row = '0;
    logic        i_Attr_Write = 1'b0;
    logic [4:0]  i_Attr_Addr = '0;
    logic [11:0] i_Attr_Data = '0;
    logic [1:0]  i_Rom_Pixel = '0;
    logic [11:0] o_Attr_Rd_Data;
    logic [5:0]  o_Rom_Sprite_Num;
    logic [2:0]  o_Rom_Row;
    logic [2:0]  o_Rom_Col;
    logic        o_Lr_Write;
    logic [10:0] o_Lr_Addr;
    logic [1:0]  o_Lr_Data;
    logic        o_Busy;
    logic        o_Overflow;

    motion_object_builder #(.NUM_SPRITES(8), .CLEAR_LEN(256)) dut (
        .i_Clk            (i_Clk),
        .i_Reset_n        (i_Reset_n),
        .i_Line_Start     (i_Line_Start),
        .i_Build_Row      (i_Build_Row),
        .i_Attr_Write     (i_Attr_Write),
        .i_Attr_Addr      (i_Attr_Addr),
        .i_Attr_Data      (i_Attr_Data),
        .o_Attr_Rd_Data   (o_Attr_Rd_Data),
        .o_Rom_Sprite_Num (o_Rom_Sprite_Num),
        .o_Rom_Row        (o_Rom_Row),
        .o_Rom_Col        (o_Rom_Col),
        .i_Rom_Pixel      (i_Rom_Pixel),
        .o_Lr_Write       (o_Lr_Write),
        .o_Lr_Addr        (o_Lr_Addr),
        .o_Lr_Data        (o_Lr_Data),
        .o_Busy           (o_Busy),
        .o_Overflow       (o_Overflow)
    );

    always #5 i_Clk = ~i_Clk;

    int vectors = 0;
    int misses  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Sprite ROM: pixel value depends on sprite, line and column; zero is transparent.
    function automatic logic [1:0] rom_fn(input logic [5:0] num, input logic [2:0] r, input logic [2:0] c);
        int s;
        s = int'(num) + int'(r) + int'(c);
        return s[1:0];
    endfunction

    always @(posedge i_Clk) i_Rom_Pixel <= rom_fn(o_Rom_Sprite_Num, o_Rom_Row, o_Rom_Col);

    // Shadow of the CPU-visible attribute table.
    logic [5:0] sh_num [8];
    logic [9:0] sh_x   [8];
    logic [9:0] sh_y   [8];
    logic       sh_en  [8];

    logic [12:0] exp_q [$];
    logic [1:0]  lr_mem [0:2047];
    int          busy_left = 0;
    int          busy_cnt  = 0;
    int          ovf_count = 0;
    logic        ovf_next  = 1'b0;
    logic [7:0]  rom_cols  = '0;
    logic [2:0]  rom_row_seen = '0;
    logic        rst_q     = 1'b0;
    logic        checking  = 1'b0;

    // Line model: clear the whole bank, then paint slots high-to-low so lower slots win.
    task automatic build_expect(input logic [9:0] r);
        int         hits;
        logic [9:0] dy;
        logic [8:0] xx;
        logic [1:0] px;
        exp_q.delete();
        hits = 0;
        for (int xh = 0; xh < 256; xh++) exp_q.push_back({2'b00, r[1], 8'(xh), 2'b00});
        for (int s = 7; s >= 0; s--) begin
            dy = r - sh_y[s];
            if (sh_en[s] && dy < 10'd16 && sh_x[s] < 10'd512) begin
                hits++;
                for (int i = 0; i < 8; i++) begin
                    px = rom_fn(sh_num[s], dy[3:1], 3'(i));
                    xx = 9'(sh_x[s] / 2) + 9'(i);
                    if (px != 2'd0 && xx <= 9'd255) exp_q.push_back({2'b00, r[1], xx[7:0], px});
                end
            end
        end
        busy_left    = 256 + 8 + 9 * hits;
        busy_cnt     = 0;
        rom_cols     = '0;
        rom_row_seen = '0;
    endtask

    always @(posedge i_Clk) rst_q <= i_Reset_n;

    always @(negedge i_Clk) begin
        logic        exp_busy;
        logic [12:0] e;
        if (checking) begin
            if (!rst_q) begin
                check("rst_busy", o_Busy, 0);
                check("rst_overflow", o_Overflow, 0);
                check("rst_lr_write", o_Lr_Write, 0);
                exp_q.delete();
                busy_left = 0;
                ovf_next  = 1'b0;
            end else begin
                exp_busy = (busy_left > 0);
                check("busy", o_Busy, exp_busy);
                check("overflow", o_Overflow, ovf_next);
                if (o_Overflow === 1'b1) ovf_count++;
                if (o_Busy === 1'b1) busy_cnt++;
                if (busy_left > 0) busy_left--;
                if (o_Rom_Sprite_Num == 6'd1) begin
                    rom_cols     = rom_cols | (8'd1 << o_Rom_Col);
                    rom_row_seen = o_Rom_Row;
                end
                if (o_Lr_Write === 1'b1) begin
                    lr_mem[o_Lr_Addr] = o_Lr_Data;
                    if (exp_q.size() == 0) begin
                        check("stray_write", o_Lr_Write, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("lr_addr", o_Lr_Addr, e[12:2]);
                        check("lr_data", o_Lr_Data, e[1:0]);
                    end
                end
                ovf_next = i_Line_Start && exp_busy;
                if (i_Line_Start) build_expect(i_Build_Row);
            end
        end
    end

    task automatic write_attr(input int slot, input int field, input int data);
        @(posedge i_Clk);
        #1;
        i_Attr_Write = 1'b1;
        i_Attr_Addr  = 5'(slot * 4 + field);
        i_Attr_Data  = 12'(data);
        @(posedge i_Clk);
        #1;
        i_Attr_Write = 1'b0;
        case (field)
            0:       sh_num[slot] = 6'(data);
            1:       sh_x[slot]   = 10'(data);
            2:       sh_y[slot]   = 10'(data);
            default: sh_en[slot]  = 1'(data & 1);
        endcase
    endtask

    task automatic read_attr(input logic [4:0] a, input logic [11:0] expected);
        @(posedge i_Clk);
        #1;
        i_Attr_Addr = a;
        @(posedge i_Clk);
        @(negedge i_Clk);
        check($sformatf("attr_rd_%0d", a), o_Attr_Rd_Data, expected);
    endtask

    task automatic clear_shadow();
        for (int s = 0; s < 8; s++) begin
            sh_num[s] = '0;
            sh_x[s]   = '0;
            sh_y[s]   = '0;
            sh_en[s]  = 1'b0;
        end
    endtask

    task automatic line_start(input logic [9:0] r);
        @(posedge i_Clk);
        #1;
        i_Line_Start = 1'b1;
        i_Build_Row  = r;
        @(posedge i_Clk);
        #1;
        i_Line_Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((busy_left != 0 || o_Busy !== 1'b0) && n < 2000) begin
            @(negedge i_Clk);
            #1;
            n++;
        end
        check({name, "_timeout"}, n < 2000, 1);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        clear_shadow();
        i_Reset_n = 1'b0;
        @(posedge i_Clk);
        checking = 1'b1;
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        check("rst_lr_addr", o_Lr_Addr, 0);
        check("rst_lr_data", o_Lr_Data, 0);
        check("rst_rom_addr", {o_Rom_Sprite_Num, o_Rom_Row, o_Rom_Col}, 0);
        check("rst_attr_rd", o_Attr_Rd_Data, 0);
        @(posedge i_Clk);
        #1;
        i_Reset_n = 1'b1;

        // Every attribute reads back zero after reset; then idle with no build.
        for (int a = 0; a < 32; a++) read_attr(5'(a), 12'd0);
        repeat (1000) @(posedge i_Clk);

        // All slots disabled: 256 zero writes to bank 0, busy for 264 cycles.
        line_start(10'd4);
        wait_done("blank");
        check("blank_busy_len", busy_cnt, 264);
        check("blank_lr_0x000", lr_mem[11'h000], 0);
        check("blank_lr_0x0ff", lr_mem[11'h0FF], 0);

        // Slot 0: num 1, x 32, y 0 at row 3 -> ROM line 1, xh 16..23 in bank 1.
        write_attr(0, 0, 1);
        write_attr(0, 1, 32);
        write_attr(0, 2, 0);
        write_attr(0, 3, 1);
        read_attr(5'd1, 12'd32);
        line_start(10'd3);
        wait_done("single");
        check("single_busy_len", busy_cnt, 273);
        check("single_rom_row", rom_row_seen, 1);
        check("single_rom_cols", rom_cols, 8'hFF);
        check("single_lr_0x110", lr_mem[11'h110], 2);
        check("single_lr_0x111", lr_mem[11'h111], 3);
        check("single_lr_0x112", lr_mem[11'h112], 0);
        check("single_lr_0x117", lr_mem[11'h117], 1);

        // Slot 5 overlaps slot 0 exactly; slot 0 must win where both are opaque.
        write_attr(5, 0, 2);
        write_attr(5, 1, 32);
        write_attr(5, 2, 0);
        write_attr(5, 3, 1);
        line_start(10'd3);
        wait_done("overlap");
        check("overlap_busy_len", busy_cnt, 282);
        check("overlap_lr_0x110", lr_mem[11'h110], 2);
        check("overlap_lr_0x111", lr_mem[11'h111], 3);
        check("overlap_lr_0x112", lr_mem[11'h112], 1);
        check("overlap_lr_0x113", lr_mem[11'h113], 1);

        // Right-edge clip at x=500 and off-screen x=600.
        write_attr(0, 3, 0);
        write_attr(5, 3, 0);
        write_attr(2, 0, 1);
        write_attr(2, 1, 500);
        write_attr(2, 2, 0);
        write_attr(2, 3, 12'hFFF);
        read_attr(5'd11, 12'd1);
        write_attr(3, 0, 3);
        write_attr(3, 1, 600);
        write_attr(3, 2, 0);
        write_attr(3, 3, 1);
        line_start(10'd3);
        wait_done("clip");
        check("clip_busy_len", busy_cnt, 273);
        check("clip_lr_0x1fa", lr_mem[11'h1FA], 2);
        check("clip_lr_0x1ff", lr_mem[11'h1FF], 3);
        check("clip_no_wrap_0x101", lr_mem[11'h101], 0);

        // Restart 100 cycles into a build: one overflow pulse, clear restarts at xh 0.
        line_start(10'd4);
        repeat (98) @(posedge i_Clk);
        line_start(10'd4);
        wait_done("restart");
        check("restart_ovf_count", ovf_count, 1);
        check("restart_busy_len", busy_cnt, 273);

        // Reset mid-fetch aborts silently and clears the attribute table.
        line_start(10'd3);
        repeat (264) @(posedge i_Clk);
        #1;
        i_Reset_n = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        i_Reset_n = 1'b1;
        clear_shadow();
        repeat (5) @(posedge i_Clk);
        @(negedge i_Clk);
        check("midrst_ovf_count", ovf_count, 1);
        check("midrst_busy", o_Busy, 0);
        read_attr(5'd9, 12'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
